// File: rtl/axi_reg_slice_pkg.sv
// Shared definitions for the AXI3 register slice: skid-buffer state
// encoding and the fixed AXI3 control-field widths.
package axi_reg_slice_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_t;

  localparam int LEN_W   = 4;
  localparam int LOCK_W  = 2;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

endpackage

// File: rtl/axi_skid_buf.sv
// Two-entry registered skid buffer. Ready and valid are flops, so no
// combinational path crosses from input handshake to output handshake.
module axi_skid_buf
  import axi_reg_slice_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_busy
);

  skid_state_t      r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

  // State, handshake flops and payload registers all advance together;
  // in_ready stays low out of reset until the first edge in EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
            r_out_data  <= i_in_data;
          end
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            r_state     <= ST_FULL;
            r_in_ready  <= 1'b0;
            r_skid_data <= i_in_data;
          end else if (!w_in_fire && w_out_fire) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end else if (w_in_fire && w_out_fire) begin
            r_out_data  <= i_in_data;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
            r_out_data <= r_skid_data;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_busy      = (r_state != ST_EMPTY);

endmodule

// File: rtl/axi_reg_slice.sv
// AXI3 register slice: each of AW, W, AR (S->M) and B, R (M->S) goes
// through its own skid buffer. This level only packs and unpacks payloads.
module axi_reg_slice
  import axi_reg_slice_pkg::*;
#(
  parameter int WIDTH_ID = 4,
  parameter int WIDTH_AD = 32,
  parameter int WIDTH_DA = 32,
  parameter int WIDTH_DS = WIDTH_DA / 8
) (
  input  logic                ACLK,
  input  logic                ARESET,
  // AW
  input  logic [WIDTH_ID-1:0] S_AWID,
  input  logic [WIDTH_AD-1:0] S_AWADDR,
  input  logic [LEN_W-1:0]    S_AWLEN,
  input  logic [LOCK_W-1:0]   S_AWLOCK,
  input  logic [SIZE_W-1:0]   S_AWSIZE,
  input  logic [BURST_W-1:0]  S_AWBURST,
  input  logic                S_AWVALID,
  output logic                S_AWREADY,
  output logic [WIDTH_ID-1:0] M_AWID,
  output logic [WIDTH_AD-1:0] M_AWADDR,
  output logic [LEN_W-1:0]    M_AWLEN,
  output logic [LOCK_W-1:0]   M_AWLOCK,
  output logic [SIZE_W-1:0]   M_AWSIZE,
  output logic [BURST_W-1:0]  M_AWBURST,
  output logic                M_AWVALID,
  input  logic                M_AWREADY,
  // W
  input  logic [WIDTH_ID-1:0] S_WID,
  input  logic [WIDTH_DA-1:0] S_WDATA,
  input  logic [WIDTH_DS-1:0] S_WSTRB,
  input  logic                S_WLAST,
  input  logic                S_WVALID,
  output logic                S_WREADY,
  output logic [WIDTH_ID-1:0] M_WID,
  output logic [WIDTH_DA-1:0] M_WDATA,
  output logic [WIDTH_DS-1:0] M_WSTRB,
  output logic                M_WLAST,
  output logic                M_WVALID,
  input  logic                M_WREADY,
  // AR
  input  logic [WIDTH_ID-1:0] S_ARID,
  input  logic [WIDTH_AD-1:0] S_ARADDR,
  input  logic [LEN_W-1:0]    S_ARLEN,
  input  logic [LOCK_W-1:0]   S_ARLOCK,
  input  logic [SIZE_W-1:0]   S_ARSIZE,
  input  logic [BURST_W-1:0]  S_ARBURST,
  input  logic                S_ARVALID,
  output logic                S_ARREADY,
  output logic [WIDTH_ID-1:0] M_ARID,
  output logic [WIDTH_AD-1:0] M_ARADDR,
  output logic [LEN_W-1:0]    M_ARLEN,
  output logic [LOCK_W-1:0]   M_ARLOCK,
  output logic [SIZE_W-1:0]   M_ARSIZE,
  output logic [BURST_W-1:0]  M_ARBURST,
  output logic                M_ARVALID,
  input  logic                M_ARREADY,
  // B
  input  logic [WIDTH_ID-1:0] M_BID,
  input  logic [RESP_W-1:0]   M_BRESP,
  input  logic                M_BVALID,
  output logic                M_BREADY,
  output logic [WIDTH_ID-1:0] S_BID,
  output logic [RESP_W-1:0]   S_BRESP,
  output logic                S_BVALID,
  input  logic                S_BREADY,
  // R
  input  logic [WIDTH_ID-1:0] M_RID,
  input  logic [WIDTH_DA-1:0] M_RDATA,
  input  logic [RESP_W-1:0]   M_RRESP,
  input  logic                M_RLAST,
  input  logic                M_RVALID,
  output logic                M_RREADY,
  output logic [WIDTH_ID-1:0] S_RID,
  output logic [WIDTH_DA-1:0] S_RDATA,
  output logic [RESP_W-1:0]   S_RRESP,
  output logic                S_RLAST,
  output logic                S_RVALID,
  input  logic                S_RREADY,
  output logic                CACTIVE
);

  localparam int AX_W = WIDTH_ID + WIDTH_AD + LEN_W + LOCK_W + SIZE_W + BURST_W;
  localparam int W_W  = WIDTH_ID + WIDTH_DA + WIDTH_DS + 1;
  localparam int B_W  = WIDTH_ID + RESP_W;
  localparam int R_W  = WIDTH_ID + WIDTH_DA + RESP_W + 1;

  logic [AX_W-1:0] w_aw_out, w_ar_out;
  logic [W_W-1:0]  w_w_out;
  logic [B_W-1:0]  w_b_out;
  logic [R_W-1:0]  w_r_out;
  logic [4:0]      w_busy;
  logic            r_cactive;

  axi_skid_buf #(.WIDTH(AX_W)) u_aw (
    .clk(ACLK), .rst(ARESET),
    .i_in_valid(S_AWVALID), .o_in_ready(S_AWREADY),
    .i_in_data({S_AWID, S_AWADDR, S_AWLEN, S_AWLOCK, S_AWSIZE, S_AWBURST}),
    .o_out_valid(M_AWVALID), .i_out_ready(M_AWREADY), .o_out_data(w_aw_out),
    .o_busy(w_busy[0])
  );
  assign {M_AWID, M_AWADDR, M_AWLEN, M_AWLOCK, M_AWSIZE, M_AWBURST} = w_aw_out;

  axi_skid_buf #(.WIDTH(W_W)) u_w (
    .clk(ACLK), .rst(ARESET),
    .i_in_valid(S_WVALID), .o_in_ready(S_WREADY),
    .i_in_data({S_WID, S_WDATA, S_WSTRB, S_WLAST}),
    .o_out_valid(M_WVALID), .i_out_ready(M_WREADY), .o_out_data(w_w_out),
    .o_busy(w_busy[1])
  );
  assign {M_WID, M_WDATA, M_WSTRB, M_WLAST} = w_w_out;

  axi_skid_buf #(.WIDTH(AX_W)) u_ar (
    .clk(ACLK), .rst(ARESET),
    .i_in_valid(S_ARVALID), .o_in_ready(S_ARREADY),
    .i_in_data({S_ARID, S_ARADDR, S_ARLEN, S_ARLOCK, S_ARSIZE, S_ARBURST}),
    .o_out_valid(M_ARVALID), .i_out_ready(M_ARREADY), .o_out_data(w_ar_out),
    .o_busy(w_busy[2])
  );
  assign {M_ARID, M_ARADDR, M_ARLEN, M_ARLOCK, M_ARSIZE, M_ARBURST} = w_ar_out;

  axi_skid_buf #(.WIDTH(B_W)) u_b (
    .clk(ACLK), .rst(ARESET),
    .i_in_valid(M_BVALID), .o_in_ready(M_BREADY),
    .i_in_data({M_BID, M_BRESP}),
    .o_out_valid(S_BVALID), .i_out_ready(S_BREADY), .o_out_data(w_b_out),
    .o_busy(w_busy[3])
  );
  assign {S_BID, S_BRESP} = w_b_out;

  axi_skid_buf #(.WIDTH(R_W)) u_r (
    .clk(ACLK), .rst(ARESET),
    .i_in_valid(M_RVALID), .o_in_ready(M_RREADY),
    .i_in_data({M_RID, M_RDATA, M_RRESP, M_RLAST}),
    .o_out_valid(S_RVALID), .i_out_ready(S_RREADY), .o_out_data(w_r_out),
    .o_busy(w_busy[4])
  );
  assign {S_RID, S_RDATA, S_RRESP, S_RLAST} = w_r_out;

  // Registered activity flag: any buffer holding data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_cactive <= 1'b0;
    else        r_cactive <= |w_busy;
  end

  assign CACTIVE = r_cactive;

endmodule

// File: tb/tb_axi_reg_slice.sv
// Self-checking bench for axi_reg_slice: reset, streaming write,
// R backpressure, AR simultaneous fire, mid-burst reset and a memory
// write/read-back through a small slave model.
module tb_axi_reg_slice;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AWID, M_AWID, S_WID, M_WID, S_ARID, M_ARID, M_BID, S_BID, M_RID, S_RID;
  logic [31:0] S_AWADDR, M_AWADDR, S_ARADDR, M_ARADDR;
  logic [3:0]  S_AWLEN, M_AWLEN, S_ARLEN, M_ARLEN;
  logic [1:0]  S_AWLOCK, M_AWLOCK, S_ARLOCK, M_ARLOCK;
  logic [2:0]  S_AWSIZE, M_AWSIZE, S_ARSIZE, M_ARSIZE;
  logic [1:0]  S_AWBURST, M_AWBURST, S_ARBURST, M_ARBURST;
  logic        S_AWVALID, S_AWREADY, M_AWVALID, M_AWREADY;
  logic [31:0] S_WDATA, M_WDATA, M_RDATA, S_RDATA;
  logic [3:0]  S_WSTRB, M_WSTRB;
  logic        S_WLAST, M_WLAST, S_WVALID, S_WREADY, M_WVALID, M_WREADY;
  logic        S_ARVALID, S_ARREADY, M_ARVALID, M_ARREADY;
  logic [1:0]  M_BRESP, S_BRESP, M_RRESP, S_RRESP;
  logic        M_BVALID, M_BREADY, S_BVALID, S_BREADY;
  logic        M_RLAST, S_RLAST, M_RVALID, M_RREADY, S_RVALID, S_RREADY;
  logic        CACTIVE;

  int errors = 0;
  int checks = 0;

  axi_reg_slice dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWID(S_AWID), .S_AWADDR(S_AWADDR), .S_AWLEN(S_AWLEN), .S_AWLOCK(S_AWLOCK),
    .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWLEN(M_AWLEN), .M_AWLOCK(M_AWLOCK),
    .M_AWSIZE(M_AWSIZE), .M_AWBURST(M_AWBURST), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .S_WID(S_WID), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WLAST(S_WLAST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .M_WID(M_WID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WLAST(M_WLAST),
    .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARLOCK(S_ARLOCK),
    .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARLOCK(M_ARLOCK),
    .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .S_BID(S_BID), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .CACTIVE(CACTIVE)
  );

  always #5 ACLK = ~ACLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic init_inputs;
    {S_AWID, S_AWADDR, S_AWLEN, S_AWLOCK, S_AWSIZE, S_AWBURST, S_AWVALID} = '0;
    {S_WID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID} = '0;
    {S_ARID, S_ARADDR, S_ARLEN, S_ARLOCK, S_ARSIZE, S_ARBURST, S_ARVALID} = '0;
    {M_BID, M_BRESP, M_BVALID, M_RID, M_RDATA, M_RRESP, M_RLAST, M_RVALID} = '0;
    {M_AWREADY, M_WREADY, M_ARREADY, S_BREADY, S_RREADY} = '0;
  endtask

  task automatic test_reset;
    logic [4:0] rdy;
    ARESET = 1'b1;
    S_AWVALID = 1'b1;
    S_AWADDR = 32'h0000_0ABC;
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++;
      if ({M_AWVALID, M_WVALID, M_ARVALID, S_BVALID, S_RVALID} !== 5'b0) begin
        errors++; $display("FAIL reset_valid cyc%0d got=%b want=00000", c,
          {M_AWVALID, M_WVALID, M_ARVALID, S_BVALID, S_RVALID});
      end
      checks++;
      if ({S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY} !== 5'b0) begin
        errors++; $display("FAIL reset_ready cyc%0d got=%b want=00000", c,
          {S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY});
      end
      checks++;
      if (CACTIVE !== 1'b0 || M_AWADDR !== 32'h0 || S_RDATA !== 32'h0) begin
        errors++; $display("FAIL reset_payload cyc%0d cactive=%b awaddr=%h rdata=%h want 0",
          c, CACTIVE, M_AWADDR, S_RDATA);
      end
    end
    ARESET = 1'b0;
    tick;
    rdy = {S_AWREADY, S_WREADY, S_ARREADY, M_BREADY, M_RREADY};
    checks++;
    if (rdy !== 5'b11111) begin
      errors++; $display("FAIL reset_release_ready got=%b want=11111", rdy);
    end
    checks++;
    if (M_AWVALID !== 1'b0 || CACTIVE !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle awvalid=%b cactive=%b want 0 0", M_AWVALID, CACTIVE);
    end
    S_AWVALID = 1'b0;
    tick;
  endtask

  task automatic test_streaming;
    logic [32:0] q[$];
    logic [32:0] exp;
    int first, last, vcnt;
    logic aw_seen;
    first = -1; last = -1; vcnt = 0; aw_seen = 1'b0;
    M_AWREADY = 1'b1;
    M_WREADY  = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (M_WVALID) begin
        if (first < 0) first = t;
        last = t;
        vcnt++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra_beat t=%0d data=%h", t, M_WDATA);
        end else begin
          exp = q.pop_front();
          if ({M_WLAST, M_WDATA} !== exp) begin
            errors++; $display("FAIL stream_wdata t=%0d got=%b/%h want=%b/%h",
              t, M_WLAST, M_WDATA, exp[32], exp[31:0]);
          end
        end
      end
      if (M_AWVALID) begin
        aw_seen = 1'b1;
        checks++;
        if (M_AWADDR !== 32'h100 || M_AWLEN !== 4'd3 || t != 1) begin
          errors++; $display("FAIL stream_aw t=%0d addr=%h len=%0d want t=1 addr=100 len=3",
            t, M_AWADDR, M_AWLEN);
        end
      end
      S_AWVALID = (t == 0);
      S_AWADDR  = 32'h100;
      S_AWLEN   = 4'd3;
      S_AWSIZE  = 3'd2;
      S_AWBURST = 2'b01;
      if (t < 4) begin
        checks++;
        if (S_WREADY !== 1'b1) begin
          errors++; $display("FAIL stream_wready t=%0d got=%b want=1", t, S_WREADY);
        end
        S_WVALID = 1'b1;
        S_WDATA  = 32'h11 * (t + 1);
        S_WLAST  = (t == 3);
        S_WSTRB  = 4'hF;
        q.push_back({S_WLAST, S_WDATA});
      end else begin
        S_WVALID = 1'b0;
        S_WLAST  = 1'b0;
      end
      tick;
    end
    checks++;
    if (first != 1 || last != 4 || vcnt != 4 || q.size() != 0) begin
      errors++; $display("FAIL stream_timing first=%0d last=%0d beats=%0d left=%0d want 1 4 4 0",
        first, last, vcnt, q.size());
    end
    checks++;
    if (!aw_seen) begin
      errors++; $display("FAIL stream_aw_missing got=0 want=1");
    end
    M_AWREADY = 1'b0;
    M_WREADY  = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [32:0] q[$];
    logic [32:0] exp;
    logic [31:0] hold;
    logic in_fire, out_fire, stall, saw_full;
    int idx, pops;
    idx = 0; pops = 0; saw_full = 1'b0;
    for (int c = 0; c < 12; c++) begin
      S_RREADY = !(c >= 2 && c <= 4);
      M_RVALID = (idx < 4);
      M_RDATA  = 32'hA0 + idx;
      M_RLAST  = (idx == 3);
      M_RID    = 4'd5;
      in_fire  = M_RVALID && M_RREADY;
      out_fire = S_RVALID && S_RREADY;
      stall    = S_RVALID && !S_RREADY;
      hold     = S_RDATA;
      if (out_fire) begin
        pops++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_dup_beat c=%0d data=%h", c, S_RDATA);
        end else begin
          exp = q.pop_front();
          if ({S_RLAST, S_RDATA} !== exp) begin
            errors++; $display("FAIL bp_rdata c=%0d got=%b/%h want=%b/%h",
              c, S_RLAST, S_RDATA, exp[32], exp[31:0]);
          end
        end
      end
      if (in_fire) begin
        q.push_back({M_RLAST, M_RDATA});
        idx++;
      end
      tick;
      if (q.size() == 2) saw_full = 1'b1;
      checks++;
      if (M_RREADY !== (q.size() != 2) || S_RVALID !== (q.size() != 0)) begin
        errors++; $display("FAIL bp_handshake c=%0d mrready=%b srvalid=%b held=%0d",
          c, M_RREADY, S_RVALID, q.size());
      end
      if (stall) begin
        checks++;
        if (S_RDATA !== hold) begin
          errors++; $display("FAIL bp_stable c=%0d got=%h want=%h", c, S_RDATA, hold);
        end
      end
    end
    checks++;
    if (pops != 4 || idx != 4 || !saw_full) begin
      errors++; $display("FAIL bp_count pops=%0d sent=%0d full=%b want 4 4 1", pops, idx, saw_full);
    end
    M_RVALID = 1'b0;
    S_RREADY = 1'b0;
  endtask

  task automatic test_simultaneous;
    M_ARREADY = 1'b1;
    S_ARVALID = 1'b1;
    S_ARADDR  = 32'h300;
    tick;
    checks++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h300) begin
      errors++; $display("FAIL simul_first valid=%b addr=%h want 1 300", M_ARVALID, M_ARADDR);
    end
    checks++;
    if (S_ARREADY !== 1'b1) begin
      errors++; $display("FAIL simul_ready_pre got=%b want=1", S_ARREADY);
    end
    S_ARADDR = 32'h304;
    tick;
    checks++;
    if (M_ARVALID !== 1'b1 || M_ARADDR !== 32'h304 || S_ARREADY !== 1'b1) begin
      errors++; $display("FAIL simul_second valid=%b addr=%h ready=%b want 1 304 1",
        M_ARVALID, M_ARADDR, S_ARREADY);
    end
    S_ARVALID = 1'b0;
    tick;
    tick;
    checks++;
    if (M_ARVALID !== 1'b0 || CACTIVE !== 1'b0) begin
      errors++; $display("FAIL simul_drain valid=%b cactive=%b want 0 0", M_ARVALID, CACTIVE);
    end
    M_ARREADY = 1'b0;
  endtask

  task automatic test_mid_reset;
    M_WREADY = 1'b1;
    S_WSTRB  = 4'hF;
    for (int b = 0; b < 2; b++) begin
      S_WVALID = 1'b1;
      S_WDATA  = 32'h5500 + b;
      S_WLAST  = 1'b0;
      tick;
    end
    S_WDATA = 32'h5502;
    checks++;
    if (M_WVALID !== 1'b1 || CACTIVE !== 1'b1) begin
      errors++; $display("FAIL midrst_busy valid=%b cactive=%b want 1 1", M_WVALID, CACTIVE);
    end
    ARESET = 1'b1;
    #1;
    checks++;
    if (M_WVALID !== 1'b0 || CACTIVE !== 1'b0 || S_WREADY !== 1'b0 || M_WDATA !== 32'h0) begin
      errors++; $display("FAIL midrst_async valid=%b cactive=%b wready=%b data=%h want 0 0 0 0",
        M_WVALID, CACTIVE, S_WREADY, M_WDATA);
    end
    S_WVALID = 1'b0;
    M_WREADY = 1'b0;
    tick;
    tick;
    ARESET = 1'b0;
    tick;
    checks++;
    if (M_WVALID !== 1'b0 || S_WREADY !== 1'b1) begin
      errors++; $display("FAIL midrst_after valid=%b wready=%b want 0 1", M_WVALID, S_WREADY);
    end
  endtask

  // Master drives one write and one read of 0x200; the slave side is a
  // small memory that answers OKAY for written addresses, DECERR otherwise.
  task automatic test_mem_readback;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] q[$];
    logic [31:0] wa, wd, ra, exp;
    logic [3:0]  wid, rid;
    logic sa, sw, ma, mw, mb, sb, mr, sr;
    logic got_aw, got_w, b_sent, b_done, got_ar, r_sent, r_done;
    got_aw = 0; got_w = 0; b_sent = 0; b_done = 0;
    wa = '0; wd = '0; wid = '0;
    S_AWVALID = 1; S_AWID = 4'd7; S_AWADDR = 32'h200; S_AWLEN = 0; S_AWSIZE = 3'd2; S_AWBURST = 2'b01;
    S_WVALID = 1; S_WID = 4'd7; S_WDATA = 32'hDEADBEEF; S_WSTRB = 4'hF; S_WLAST = 1;
    S_BREADY = 1; M_AWREADY = 1; M_WREADY = 1; M_BVALID = 0;
    for (int c = 0; c < 50 && !b_done; c++) begin
      sa = S_AWVALID && S_AWREADY; sw = S_WVALID && S_WREADY;
      ma = M_AWVALID && M_AWREADY; mw = M_WVALID && M_WREADY;
      mb = M_BVALID && M_BREADY;   sb = S_BVALID && S_BREADY;
      if (ma) begin wa = M_AWADDR; wid = M_AWID; got_aw = 1; end
      if (mw) begin wd = M_WDATA; got_w = 1; end
      if (sb) begin
        b_done = 1;
        checks++;
        if (S_BRESP !== 2'b00 || S_BID !== 4'd7) begin
          errors++; $display("FAIL mem_bresp got=%b id=%0d want 00 id=7", S_BRESP, S_BID);
        end
      end
      tick;
      if (sa) S_AWVALID = 0;
      if (sw) S_WVALID = 0;
      if (mb) M_BVALID = 0;
      if (got_aw && got_w && !b_sent) begin
        mem[wa] = wd; b_sent = 1;
        M_BVALID = 1; M_BID = wid; M_BRESP = 2'b00;
      end
    end
    if (!b_done) begin
      checks++; errors++; $display("FAIL mem_write_timeout got=0 want=1");
    end
    S_BREADY = 0; M_AWREADY = 0; M_WREADY = 0;

    got_ar = 0; r_sent = 0; r_done = 0; ra = '0; rid = '0;
    S_ARVALID = 1; S_ARID = 4'd9; S_ARADDR = 32'h200; S_ARLEN = 0; S_ARSIZE = 3'd2; S_ARBURST = 2'b01;
    q.push_back(32'hDEADBEEF);
    S_RREADY = 1; M_ARREADY = 1; M_RVALID = 0;
    for (int c = 0; c < 50 && !r_done; c++) begin
      sa = S_ARVALID && S_ARREADY; ma = M_ARVALID && M_ARREADY;
      mr = M_RVALID && M_RREADY;   sr = S_RVALID && S_RREADY;
      if (ma) begin ra = M_ARADDR; rid = M_ARID; got_ar = 1; end
      if (sr) begin
        r_done = 1;
        exp = q.pop_front();
        checks++;
        if (S_RDATA !== exp || S_RLAST !== 1'b1 || S_RID !== 4'd9) begin
          errors++; $display("FAIL mem_rdata got=%h last=%b id=%0d want=%h 1 9", S_RDATA, S_RLAST, S_RID, exp);
        end
        checks++;
        if (S_RRESP !== 2'b00) begin
          errors++; $display("FAIL mem_rresp got=%b want=00", S_RRESP);
        end
      end
      tick;
      if (sa) S_ARVALID = 0;
      if (mr) M_RVALID = 0;
      if (got_ar && !r_sent) begin
        r_sent = 1; M_RVALID = 1; M_RID = rid; M_RLAST = 1;
        if (mem.exists(ra)) begin M_RDATA = mem[ra]; M_RRESP = 2'b00; end
        else begin M_RDATA = 32'h0; M_RRESP = 2'b11; end
      end
    end
    if (!r_done) begin
      checks++; errors++; $display("FAIL mem_read_timeout got=0 want=1");
    end
    S_RREADY = 0; M_ARREADY = 0;
    tick;
    tick;
    checks++;
    if (CACTIVE !== 1'b0) begin
      errors++; $display("FAIL mem_idle_cactive got=%b want=0", CACTIVE);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_mid_reset();
    test_mem_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
